// File: rtl/pll_clk_manager_if.sv
// Status/control bundle between the clock manager and the rest of the chip.
// The master side is the manager: it reads the PLL lock and drives everything else.
interface pll_clk_manager_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
);
  logic              pll_lock_i;
  logic              pll_resetb_o;
  logic              sys_rst_o;
  logic              ready_o;
  logic [NUM_CH-1:0] ce_o;
  logic [2:0]        state_o;
  logic [CNT_W-1:0]  retry_cnt_o;
  logic [CNT_W-1:0]  lock_loss_cnt_o;

  modport master (
    input  pll_lock_i,
    output pll_resetb_o, sys_rst_o, ready_o, ce_o, state_o, retry_cnt_o, lock_loss_cnt_o
  );

  modport slave (
    output pll_lock_i,
    input  pll_resetb_o, sys_rst_o, ready_o, ce_o, state_o, retry_cnt_o, lock_loss_cnt_o
  );
endinterface

// File: rtl/pll_clk_manager.sv
// PLL reset sequencer, lock qualifier and system-reset generator running on the
// reference clock, plus NUM_CH phase-accumulator clock-enable generators.
module pll_clk_manager #(
  parameter int                       PLL_RST_CYCLES = 16,
  parameter int                       LOCK_TIMEOUT   = 4096,
  parameter int                       LOCK_FILTER    = 256,
  parameter int                       RST_HOLD       = 64,
  parameter int                       NUM_CH         = 2,
  parameter int                       ACC_W          = 16,
  parameter logic [NUM_CH*ACC_W-1:0]  INCR           = {16'd1, 16'd1},
  parameter int                       CNT_W          = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  pll_clk_manager_if.master   bus
);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    FILTER    = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4
  } state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX   = max_of(max_of(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                  max_of(LOCK_FILTER, RST_HOLD));
  localparam int TIMER_W = $clog2(T_MAX) + 1;

  localparam logic [TIMER_W-1:0] T_PLL     = TIMER_W'(PLL_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T_TIMEOUT = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] T_FILTER  = TIMER_W'(LOCK_FILTER - 1);
  localparam logic [TIMER_W-1:0] T_HOLD    = TIMER_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  logic               sync_q;
  logic               lock_s;
  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q;
  logic [CNT_W-1:0]   retry_q, loss_q;
  logic               retry_inc, loss_inc;
  logic               resetb_d, sys_rst_d, ready_d;
  logic               resetb_q, sys_rst_q, ready_q;
  logic [ACC_W-1:0]   acc_q [NUM_CH];
  logic [ACC_W:0]     sum   [NUM_CH];
  logic [NUM_CH-1:0]  ce_q;

  // Two-flop synchroniser: PLL LOCK has no timing relation to clk_i.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments keep both flops sampling the pre-edge values;
    // a blocking pair here would collapse into a single flop.
    if (rst_i) begin
      sync_q <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync_q <= bus.pll_lock_i;
      lock_s <= sync_q;
    end
  end

  // State register, shared timer and saturating event counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= PLL_RST;
      timer_q <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= (state_d != state_q) ? '0 : timer_q + TIMER_W'(1);
      if (retry_inc && retry_q != CNT_MAX) retry_q <= retry_q + CNT_W'(1);
      if (loss_inc && loss_q != CNT_MAX)   loss_q  <= loss_q + CNT_W'(1);
    end
  end

  // Lock checks come first in every state so a lock drop beats a terminal count.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d   = state_q;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    unique case (state_q)
      PLL_RST:   if (timer_q == T_PLL) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_s) state_d = FILTER;
        else if (timer_q == T_TIMEOUT) begin
          state_d   = PLL_RST;
          retry_inc = 1'b1;
        end
      end
      FILTER: begin
        if (!lock_s)                  state_d = WAIT_LOCK;
        else if (timer_q == T_FILTER) state_d = HOLD;
      end
      HOLD: begin
        if (!lock_s)                state_d = WAIT_LOCK;
        else if (timer_q == T_HOLD) state_d = RUN;
      end
      RUN: begin
        if (!lock_s) begin
          state_d  = PLL_RST;
          loss_inc = 1'b1;
        end
      end
      default: state_d = PLL_RST;
    endcase
  end

  // Outputs decode the next state so they flip on the same edge as state_o.
  always_comb begin
    resetb_d  = (state_d != PLL_RST);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resetb_q  <= 1'b0;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      resetb_q  <= resetb_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      sum[k] = {1'b0, acc_q[k]} + {1'b0, INCR[k*ACC_W +: ACC_W]};
    end
  end

  // Accumulators are gated by the next state, so leaving RUN never leaves a stray pulse.
  always_ff @(posedge clk_i) begin
    // NOTE: the accumulator array is a bank of flops, not a RAM, so it is reset
    // explicitly along with everything else.
    if (rst_i || state_d != RUN) begin
      for (int k = 0; k < NUM_CH; k++) acc_q[k] <= '0;
      ce_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        acc_q[k] <= sum[k][ACC_W-1:0];
        ce_q[k]  <= sum[k][ACC_W];
      end
    end
  end

  assign bus.pll_resetb_o    = resetb_q;
  assign bus.sys_rst_o       = sys_rst_q;
  assign bus.ready_o         = ready_q;
  assign bus.ce_o            = ce_q;
  assign bus.state_o         = state_q;
  assign bus.retry_cnt_o     = retry_q;
  assign bus.lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_pll_clk_manager.sv
// Self-checking bench for pll_clk_manager: vector table, corner sequences and a
// randomised run against a rule-level reference model.
module tb_pll_clk_manager;

  localparam int P_RST  = 4;
  localparam int P_TO   = 16;
  localparam int P_FILT = 8;
  localparam int P_HOLD = 5;
  localparam int NUM_CH = 2;
  localparam int ACC_W  = 4;
  localparam int CNT_W  = 2;
  localparam int INC0   = 4;
  localparam int INC1   = 0;
  localparam int SAT    = 3;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic lock = 1'b0;

  always #5 clk = ~clk;

  pll_clk_manager_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();
  assign bus.pll_lock_i = lock;

  pll_clk_manager #(
    .PLL_RST_CYCLES (P_RST),
    .LOCK_TIMEOUT   (P_TO),
    .LOCK_FILTER    (P_FILT),
    .RST_HOLD       (P_HOLD),
    .NUM_CH         (NUM_CH),
    .ACC_W          (ACC_W),
    .INCR           ({4'd0, 4'd4}),
    .CNT_W          (CNT_W)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int tgt, input int budget, input string name);
    int n = 0;
    while (bus.state_o !== 3'(tgt) && n < budget) begin
      tick();
      n++;
    end
    check(name, bus.state_o, tgt);
  endtask

  // Vector record: inputs held for n cycles, outputs expected after each of them.
  typedef struct {
    int n;
    bit r;
    bit l;
    int st;
    bit rb;
    bit sr;
    bit rdy;
    int ce;
    int retry;
    int loss;
  } vec_t;

  vec_t vecs[$];

  // Reference model: spec rules stepped once per clock edge.
  int m_st, m_tm, m_run, m_retry, m_loss;
  bit m_h0, m_h1;

  function automatic void model_step(input bit r, input bit l);
    int nx;
    if (r) begin
      m_st = 0; m_tm = 0; m_run = 0; m_retry = 0; m_loss = 0; m_h0 = 0; m_h1 = 0;
      return;
    end
    nx = m_st;
    case (m_st)
      0: if (m_tm == P_RST - 1) nx = 1;
      1: if (m_h1) nx = 2;
         else if (m_tm == P_TO - 1) begin nx = 0; if (m_retry < SAT) m_retry++; end
      2: if (!m_h1) nx = 1; else if (m_tm == P_FILT - 1) nx = 3;
      3: if (!m_h1) nx = 1; else if (m_tm == P_HOLD - 1) nx = 4;
      default: if (!m_h1) begin nx = 0; if (m_loss < SAT) m_loss++; end
    endcase
    m_tm  = (nx != m_st) ? 0 : m_tm + 1;
    m_st  = nx;
    m_h1  = m_h0;
    m_h0  = l;
    m_run = (nx == 4) ? m_run + 1 : 0;
  endfunction

  // A channel pulses whenever the running phase total crosses a multiple of 2^ACC_W.
  function automatic int model_ce();
    int ce = 0;
    if (m_run > 0) begin
      if ((m_run * INC0) / 16 != ((m_run - 1) * INC0) / 16) ce |= 1;
      if ((m_run * INC1) / 16 != ((m_run - 1) * INC1) / 16) ce |= 2;
    end
    return ce;
  endfunction

  task automatic step_rand(input bit r, input bit l);
    rst  = r;
    lock = l;
    tick();
    model_step(r, l);
    check("rnd_state",  bus.state_o,         m_st);
    check("rnd_resetb", bus.pll_resetb_o,    int'(m_st != 0));
    check("rnd_sysrst", bus.sys_rst_o,       int'(m_st != 4));
    check("rnd_ready",  bus.ready_o,         int'(m_st == 4));
    check("rnd_ce",     bus.ce_o,            model_ce());
    check("rnd_retry",  bus.retry_cnt_o,     m_retry);
    check("rnd_loss",   bus.lock_loss_cnt_o, m_loss);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // n, rst, lock | state, resetb, sys_rst, ready, ce, retry, loss
    vecs.push_back('{3, 1, 0, 0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{3, 0, 0, 0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 1, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{2, 0, 0, 1, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{2, 0, 1, 1, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 2, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{7, 0, 1, 2, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 3, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{4, 0, 1, 3, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 4, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{2, 0, 1, 4, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 4, 1, 0, 1, 1, 0, 0});
    vecs.push_back('{1, 0, 1, 4, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{2, 0, 1, 4, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 4, 1, 0, 1, 1, 0, 0});
    vecs.push_back('{1, 0, 1, 4, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 4, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 4, 1, 0, 1, 0, 0, 0});
    // Leaving edge coincides with an accumulator wrap: no pulse may escape.
    vecs.push_back('{1, 0, 0, 0, 0, 1, 0, 0, 0, 1});

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        rst  = vecs[i].r;
        lock = vecs[i].l;
        tick();
        check($sformatf("vec%0d_state", i),  bus.state_o,         vecs[i].st);
        check($sformatf("vec%0d_resetb", i), bus.pll_resetb_o,    vecs[i].rb);
        check($sformatf("vec%0d_sysrst", i), bus.sys_rst_o,       vecs[i].sr);
        check($sformatf("vec%0d_ready", i),  bus.ready_o,         vecs[i].rdy);
        check($sformatf("vec%0d_ce", i),     bus.ce_o,            vecs[i].ce);
        check($sformatf("vec%0d_retry", i),  bus.retry_cnt_o,     vecs[i].retry);
        check($sformatf("vec%0d_loss", i),   bus.lock_loss_cnt_o, vecs[i].loss);
      end
    end

    // Glitchy lock: one-cycle drop at the fifth filter cycle.
    rst = 1'b1; lock = 1'b0; tick();
    rst = 1'b0; lock = 1'b1;
    wait_state(2, 20, "glitch_reach_filter");
    repeat (4) tick();
    lock = 1'b0; tick();
    check("glitch_j1_state", bus.state_o, 2);
    lock = 1'b1; tick();
    check("glitch_j2_state", bus.state_o, 2);
    tick();
    check("glitch_j3_state", bus.state_o, 1);
    check("glitch_j3_sysrst", bus.sys_rst_o, 1);
    for (int j = 4; j <= 11; j++) begin
      tick();
      check($sformatf("glitch_j%0d_state", j), bus.state_o, 2);
      check($sformatf("glitch_j%0d_sysrst", j), bus.sys_rst_o, 1);
    end
    for (int j = 12; j <= 16; j++) begin
      tick();
      check($sformatf("glitch_j%0d_state", j), bus.state_o, 3);
      check($sformatf("glitch_j%0d_sysrst", j), bus.sys_rst_o, 1);
    end
    tick();
    check("glitch_j17_state", bus.state_o, 4);
    check("glitch_j17_sysrst", bus.sys_rst_o, 0);

    // Timeout retry: 4 cycles in PLL reset, 16 waiting, repeating; counter saturates.
    rst = 1'b1; lock = 1'b0; tick();
    rst = 1'b0;
    for (int t = 1; t <= 80; t++) begin
      tick();
      check($sformatf("timeout_t%0d_resetb", t), bus.pll_resetb_o, int'((t % 20) >= 4));
      check($sformatf("timeout_t%0d_state", t),  bus.state_o,      ((t % 20) >= 4) ? 1 : 0);
      check($sformatf("timeout_t%0d_retry", t),  bus.retry_cnt_o,  (t / 20 > SAT) ? SAT : t / 20);
    end

    // Reset pulse mid-HOLD clears everything and restarts the sequence.
    lock = 1'b1;
    wait_state(3, 60, "midhold_reach_hold");
    tick();
    rst = 1'b1; tick();
    check("midhold_state",  bus.state_o,         0);
    check("midhold_resetb", bus.pll_resetb_o,    0);
    check("midhold_sysrst", bus.sys_rst_o,       1);
    check("midhold_ready",  bus.ready_o,         0);
    check("midhold_retry",  bus.retry_cnt_o,     0);
    check("midhold_loss",   bus.lock_loss_cnt_o, 0);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("restart_c%0d_state", i), bus.state_o, 0);
      check($sformatf("restart_c%0d_resetb", i), bus.pll_resetb_o, 0);
    end
    tick();
    check("restart_c4_state", bus.state_o, 1);
    tick();
    check("restart_c5_state", bus.state_o, 2);

    // Randomised lock behaviour against the reference model.
    step_rand(1'b1, 1'b0);
    begin
      int cyc = 0;
      while (cyc < 3000) begin
        int seg = $urandom_range(1, 60);
        bit l   = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 39) == 0) begin
          step_rand(1'b1, l);
          cyc++;
        end
        for (int s = 0; s < seg; s++) begin
          step_rand(1'b0, l);
          cyc++;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_clk_manager.md
Name: pll_clk_manager

Overview:
- Parametrised clock-management controller that runs on the 12 MHz reference clock alongside the iCE40UP5k PLL primitive.
- Sequences the PLL reset, qualifies the asynchronous LOCK signal, and retries the PLL on lock timeout.
- Holds the system reset until the clock is stable and re-asserts it on loss of lock.
- Generates NUM_CH independent fractional clock-enable ticks (phase-accumulator NCOs) for slow peripherals, e.g. SCCB and debounce.

Parameters:
- PLL_RST_CYCLES, 16: cycles pll_resetb_o is held low per PLL reset attempt (>=1).
- LOCK_TIMEOUT, 4096: cycles to wait for lock before retrying the PLL reset (>=1).
- LOCK_FILTER, 256: cycles synchronised lock must stay high before it is accepted (>=1).
- RST_HOLD, 64: cycles sys_rst_o stays high after lock is accepted (>=1).
- NUM_CH, 2: number of clock-enable channels (>=1).
- ACC_W, 16: phase-accumulator width per channel.
- INCR, {16'd1,16'd1}: packed NUM_CH x ACC_W increments; channel k uses bits [k*ACC_W +: ACC_W].
- CNT_W, 8: width of the retry and lock-loss counters.

Ports:
- clk_i, input, 1: 12 MHz reference clock.
- rst_i, input, 1: synchronous active-high reset.
- pll_lock_i, input, 1: PLL LOCK, asynchronous to clk_i.
- pll_resetb_o, output, 1: to PLL RESETB (active-low).
- sys_rst_o, output, 1: system reset, active-high.
- ready_o, output, 1: high only in RUN.
- ce_o, output, NUM_CH: one-cycle enable pulses per channel.
- state_o, output, 3: current FSM state encoding.
- retry_cnt_o, output, CNT_W: lock-timeout retries, saturating.
- lock_loss_cnt_o, output, CNT_W: lock losses seen in RUN, saturating.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset values:
  - state = PLL_RST (0), shared timer = 0.
  - pll_resetb_o = 0, sys_rst_o = 1, ready_o = 0, ce_o = 0.
  - Both counters = 0, all accumulators = 0, synchroniser flops = 0.
- Lock synchroniser:
  - 2-flop synchroniser on pll_lock_i gives lock_s.
  - The FSM sees a pll_lock_i change 2 cycles later.
- States: PLL_RST=0, WAIT_LOCK=1, FILTER=2, HOLD=3, RUN=4.
  - The timer clears on every state entry and increments each cycle in the state.
  - "Timer == N-1" means exactly N cycles were spent in the state.
- PLL_RST:
  - pll_resetb_o = 0.
  - Go to WAIT_LOCK when timer == PLL_RST_CYCLES-1.
- WAIT_LOCK:
  - pll_resetb_o = 1.
  - If lock_s is high, go to FILTER.
  - Else if timer == LOCK_TIMEOUT-1, go to PLL_RST and increment retry_cnt_o (saturating).
- FILTER:
  - If lock_s is low, go to WAIT_LOCK; the timeout restarts.
  - Else if timer == LOCK_FILTER-1, go to HOLD.
- HOLD:
  - If lock_s is low, go to WAIT_LOCK.
  - Else if timer == RST_HOLD-1, go to RUN.
- RUN:
  - If lock_s is low, go to PLL_RST and increment lock_loss_cnt_o (saturating).
- Outputs are registered from the next state, so they change on the same edge as state_o.
  - sys_rst_o = 1 in every state except RUN.
  - ready_o = (state == RUN).
  - pll_resetb_o = 0 only in PLL_RST.
- Simultaneous events:
  - If lock_s drops on the same cycle a timer reaches its terminal value, the lock drop wins.
  - If the lock_s rise and the timeout coincide in WAIT_LOCK, lock wins and the FSM goes to FILTER.
- Counters hold at 2^CNT_W-1.
- NCO, per channel k:
  - Only in RUN: {carry, acc_k} <= acc_k + INCR_k in ACC_W+1 bits, and ce_o[k] <= carry (registered).
  - Outside RUN: acc_k = 0 and ce_o[k] = 0.
  - Mean pulse rate = f_clk * INCR_k / 2^ACC_W.
  - INCR_k = 0 never pulses. At most one pulse per cycle.
  - Leaving RUN clears acc_k and ce_o[k] on the next edge; there are no partial pulses.
- rst_i mid-operation: returns to reset values on the next edge, whatever the state. Counters clear.

Test Plan (PLL_RST_CYCLES=4, LOCK_TIMEOUT=16, LOCK_FILTER=8, RST_HOLD=5, NUM_CH=2, ACC_W=4, INCR={4'd0,4'd4}, CNT_W=2):
- Nominal bring-up:
  - Stimulus: rst_i high 3 cycles then low; raise pll_lock_i 6 cycles later.
  - Response: pll_resetb_o low for exactly 4 cycles after reset release. state_o follows 1→2→3→4. sys_rst_o falls and ready_o rises 2+8+5 cycles after the pll_lock_i rise (synchroniser + FILTER + HOLD).
- Timeout retry:
  - Stimulus: pll_lock_i held low.
  - Response: pll_resetb_o is low 4 cycles, high 16 cycles, repeating. retry_cnt_o counts 1,2,3 then saturates at 3.
- Glitchy lock:
  - Stimulus: in FILTER, drop pll_lock_i for 1 cycle at filter cycle 5.
  - Response: the FSM returns to WAIT_LOCK, then needs a full 8 further filter cycles; sys_rst_o stays high throughout.
- Lock loss in RUN:
  - Stimulus: deassert pll_lock_i.
  - Response: 2 cycles later state_o = 0, sys_rst_o = 1, ready_o = 0, pll_resetb_o = 0, lock_loss_cnt_o = 1, ce_o = 0.
- NCO:
  - Stimulus: enter RUN.
  - Response: ce_o[0] pulses on the 4th, 8th, 12th RUN cycles and so on (period 4, width 1). ce_o[1] is never high.
- Reset mid-HOLD:
  - Stimulus: assert rst_i for 1 cycle during HOLD.
  - Response: next edge gives state_o = 0, pll_resetb_o = 0, counters 0, and the full sequence restarts.
